// File: rtl/sddr_device_model.sv
// rtl/sddr_device_model.sv - DDR3 device responder: command decode, bank tracking, burst RAM, sticky errors
// Define SDDR_MODEL_TIMING_CHECK_EN to build the tRCD/tRP/tRFC checker behind err_o[1].
module sddr_device_model #(
    parameter int BANK_BITS         = 3,
    parameter int ROW_BITS          = 13,
    parameter int COL_BITS          = 10,
    parameter int DATA_BITS         = 16,
    parameter int BURST_LENGTH      = 8,
    parameter int MEM_ADDR_BITS     = 10,
    parameter int CAS_LATENCY       = 6,
    parameter int CAS_WRITE_LATENCY = 5,
    parameter int T_RCD             = 6,
    parameter int T_RP              = 6,
    parameter int T_RFC             = 64
) (
    input  logic                                          ddr_clock_i,
    input  logic                                          ddr_reset_n_i,
    input  logic                                          ddr3_cke_i,
    input  logic                                          ddr3_cs_n_i,
    input  logic                                          ddr3_ras_n_i,
    input  logic                                          ddr3_cas_n_i,
    input  logic                                          ddr3_we_n_i,
    input  logic [BANK_BITS-1:0]                          ddr3_ba_i,
    input  logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0]       ddr3_addr_i,
    input  logic [DATA_BITS-1:0]                          ddr3_dq_i [1:0],
    output logic [DATA_BITS-1:0]                          ddr3_dq_o [1:0],
    output logic                                          ddr3_dq_oe_o,
    output logic [3:0]                                    err_o,
    output logic [15:0]                                   refresh_count_o
);
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int PAIRS     = BURST_LENGTH / 2;
    localparam int BEAT_BITS = $clog2(PAIRS);
    localparam int FULL_BITS = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int HI_BITS   = MEM_ADDR_BITS - BEAT_BITS - 1;
    localparam int PL_BITS   = 1 + BANK_BITS + HI_BITS;
    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(PAIRS - 1);

    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
        if (!ddr_reset_n_i) rst_sync_q <= 2'b00;
        else                rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_bad, cmd_live;
    always_comb begin
        cmd_act  = 1'b0;
        cmd_rd   = 1'b0;
        cmd_wr   = 1'b0;
        cmd_pre  = 1'b0;
        cmd_ref  = 1'b0;
        cmd_bad  = 1'b0;
        cmd_live = ddr3_cke_i && !ddr3_cs_n_i && ({ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i} != 3'b111);
        if (cmd_live) begin
            case ({ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i})
                3'b011:  cmd_act = 1'b1;
                3'b101:  cmd_rd  = 1'b1;
                3'b100:  cmd_wr  = 1'b1;
                3'b010:  cmd_pre = 1'b1;
                3'b001:  cmd_ref = 1'b1;
                3'b110:  cmd_bad = 1'b1;
                default: ;  // MRS: accepted, no modelled mode state
            endcase
        end
    end

    logic [NUM_BANKS-1:0] bank_open, close_mask, open_eff;
    logic [ROW_BITS-1:0]  open_row [NUM_BANKS];
    logic                 rd_close_v, wr_close_v;
    logic [BANK_BITS-1:0] rd_close_ba, wr_close_ba;
    logic                 sel_open;
    logic [10:0]          col_full;
    logic [FULL_BITS-1:0] full_addr;
    logic [PL_BITS-1:0]   cmd_pl;

    // A bank finishing auto-precharge this edge already counts as closed for the incoming command.
    always_comb begin
        close_mask = '0;
        if (rd_close_v) close_mask[rd_close_ba] = 1'b1;
        if (wr_close_v) close_mask[wr_close_ba] = 1'b1;
    end
    assign open_eff  = bank_open & ~close_mask;
    assign sel_open  = open_eff[ddr3_ba_i];
    assign col_full  = {ddr3_addr_i[11], ddr3_addr_i[9:0]};
    assign full_addr = {ddr3_ba_i, open_row[ddr3_ba_i], col_full[COL_BITS-1:0]};
    assign cmd_pl    = {ddr3_addr_i[10], ddr3_ba_i, full_addr[MEM_ADDR_BITS-1:BEAT_BITS+1]};

    logic                 misc_unused;
    assign misc_unused = ^{col_full, full_addr, ddr3_addr_i};

    logic [BEAT_BITS-1:0] rd_gap, wr_gap;
    logic                 rd_ok, wr_ok, timing_err;
    logic [3:0]           err_now;
    assign rd_ok      = cmd_rd && sel_open && (rd_gap == '0);
    assign wr_ok      = cmd_wr && sel_open && (wr_gap == '0);
    assign err_now[0] = ((cmd_rd || cmd_wr) && !sel_open) || (cmd_act && sel_open) || (cmd_ref && |open_eff);
    assign err_now[1] = timing_err;
    assign err_now[2] = (cmd_rd && sel_open && rd_gap != '0) || (cmd_wr && sel_open && wr_gap != '0);
    assign err_now[3] = cmd_bad;

    always_ff @(posedge ddr_clock_i) begin
        if (cmd_act) open_row[ddr3_ba_i] <= ddr3_addr_i[ROW_BITS-1:0];
    end

    always_ff @(posedge ddr_clock_i or negedge rst_n) begin
        if (!rst_n) begin
            bank_open       <= '0;
            err_o           <= '0;
            refresh_count_o <= '0;
            rd_gap          <= '0;
            wr_gap          <= '0;
        end else begin
            bank_open <= open_eff;
            if (cmd_pre) begin
                if (ddr3_addr_i[10]) bank_open <= '0;
                else                 bank_open[ddr3_ba_i] <= 1'b0;
            end
            if (cmd_act) bank_open[ddr3_ba_i] <= 1'b1;
            err_o <= err_o | err_now;
            if (cmd_ref) refresh_count_o <= refresh_count_o + 16'd1;
            if (rd_ok) rd_gap <= BEAT_LAST;
            else if (rd_gap != '0) rd_gap <= rd_gap - 1'b1;
            if (wr_ok) wr_gap <= BEAT_LAST;
            else if (wr_gap != '0) wr_gap <= wr_gap - 1'b1;
        end
    end

    // Accepted commands ride a latency delay line, then a 4-cycle burst engine walks the pairs.
    logic [DATA_BITS-1:0]         mem [2**MEM_ADDR_BITS];
    logic [CAS_LATENCY-1:0]       rd_pv;
    logic [PL_BITS-1:0]           rd_pd [CAS_LATENCY];
    logic [CAS_WRITE_LATENCY-1:0] wr_pv;
    logic [PL_BITS-1:0]           wr_pd [CAS_WRITE_LATENCY];
    logic                         rd_act, wr_act, rd_start, wr_start, rd_now, wr_now;
    logic [BEAT_BITS-1:0]         rd_beat, wr_beat, rd_pair, wr_pair;
    logic [PL_BITS-1:0]           rd_pl, wr_pl;
    logic [HI_BITS-1:0]           rd_hi, wr_hi;

    assign rd_start = rd_pv[CAS_LATENCY-1];
    assign rd_now   = rd_start || rd_act;
    assign rd_pair  = rd_start ? '0 : rd_beat;
    assign rd_hi    = rd_start ? rd_pd[CAS_LATENCY-1][HI_BITS-1:0] : rd_pl[HI_BITS-1:0];
    assign wr_start = wr_pv[CAS_WRITE_LATENCY-1];
    assign wr_now   = wr_start || wr_act;
    assign wr_pair  = wr_start ? '0 : wr_beat;
    assign wr_hi    = wr_start ? wr_pd[CAS_WRITE_LATENCY-1][HI_BITS-1:0] : wr_pl[HI_BITS-1:0];

    always_ff @(posedge ddr_clock_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_pv <= '0;
            wr_pv <= '0;
            for (int i = 0; i < CAS_LATENCY; i++)       rd_pd[i] <= '0;
            for (int i = 0; i < CAS_WRITE_LATENCY; i++) wr_pd[i] <= '0;
            rd_act <= 1'b0; rd_beat <= '0; rd_pl <= '0;
            wr_act <= 1'b0; wr_beat <= '0; wr_pl <= '0;
            rd_close_v <= 1'b0; rd_close_ba <= '0;
            wr_close_v <= 1'b0; wr_close_ba <= '0;
            ddr3_dq_oe_o <= 1'b0;
            ddr3_dq_o[0] <= '0;
            ddr3_dq_o[1] <= '0;
        end else begin
            rd_pv[0] <= rd_ok;
            rd_pd[0] <= cmd_pl;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                rd_pv[i] <= rd_pv[i-1];
                rd_pd[i] <= rd_pd[i-1];
            end
            wr_pv[0] <= wr_ok;
            wr_pd[0] <= cmd_pl;
            for (int i = 1; i < CAS_WRITE_LATENCY; i++) begin
                wr_pv[i] <= wr_pv[i-1];
                wr_pd[i] <= wr_pd[i-1];
            end
            if (rd_start) begin
                rd_act <= 1'b1; rd_beat <= BEAT_BITS'(1); rd_pl <= rd_pd[CAS_LATENCY-1];
            end else if (rd_act) begin
                rd_beat <= rd_beat + 1'b1;
                if (rd_beat == BEAT_LAST) rd_act <= 1'b0;
            end
            if (wr_start) begin
                wr_act <= 1'b1; wr_beat <= BEAT_BITS'(1); wr_pl <= wr_pd[CAS_WRITE_LATENCY-1];
            end else if (wr_act) begin
                wr_beat <= wr_beat + 1'b1;
                if (wr_beat == BEAT_LAST) wr_act <= 1'b0;
            end
            rd_close_v   <= rd_act && rd_beat == BEAT_LAST && rd_pl[PL_BITS-1];
            rd_close_ba  <= rd_pl[PL_BITS-2 -: BANK_BITS];
            wr_close_v   <= wr_act && wr_beat == BEAT_LAST && wr_pl[PL_BITS-1];
            wr_close_ba  <= wr_pl[PL_BITS-2 -: BANK_BITS];
            ddr3_dq_oe_o <= rd_now;
            ddr3_dq_o[0] <= rd_now ? mem[{rd_hi, rd_pair, 1'b0}] : '0;
            ddr3_dq_o[1] <= rd_now ? mem[{rd_hi, rd_pair, 1'b1}] : '0;
        end
    end

    // Write and read of the same beat in one cycle: read sees the old word, RAM keeps the new one.
    always_ff @(posedge ddr_clock_i) begin
        if (wr_now) begin
            mem[{wr_hi, wr_pair, 1'b0}] <= ddr3_dq_i[0];
            mem[{wr_hi, wr_pair, 1'b1}] <= ddr3_dq_i[1];
        end
    end

`ifdef SDDR_MODEL_TIMING_CHECK_EN
    localparam int TCW = $clog2(T_RCD + T_RP + T_RFC + 1);
    logic [TCW-1:0] rcd_cnt [NUM_BANKS];
    logic [TCW-1:0] rp_cnt [NUM_BANKS];
    logic [TCW-1:0] rfc_cnt;

    assign timing_err = ((cmd_rd || cmd_wr) && sel_open && rcd_cnt[ddr3_ba_i] != '0)
                     || (cmd_act && rp_cnt[ddr3_ba_i] != '0)
                     || (cmd_live && rfc_cnt != '0);

    always_ff @(posedge ddr_clock_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_cnt[b] <= '0;
                rp_cnt[b]  <= '0;
            end
            rfc_cnt <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (cmd_act && ddr3_ba_i == BANK_BITS'(b)) rcd_cnt[b] <= TCW'(T_RCD - 1);
                else if (rcd_cnt[b] != '0)                 rcd_cnt[b] <= rcd_cnt[b] - TCW'(1);
                if ((cmd_pre && (ddr3_addr_i[10] || ddr3_ba_i == BANK_BITS'(b))) || close_mask[b])
                    rp_cnt[b] <= TCW'(T_RP - 1);
                else if (rp_cnt[b] != '0)
                    rp_cnt[b] <= rp_cnt[b] - TCW'(1);
            end
            if (cmd_ref)             rfc_cnt <= TCW'(T_RFC - 1);
            else if (rfc_cnt != '0)  rfc_cnt <= rfc_cnt - TCW'(1);
        end
    end
`else
    logic [31:0] timing_unused;
    assign timing_unused = T_RCD + T_RP + T_RFC;
    assign timing_err    = 1'b0;
`endif
endmodule

// File: tb/tb_sddr_device_model.sv
// tb/tb_sddr_device_model.sv - scoreboard bench for sddr_device_model against a behavioural DDR3 model
module tb_sddr_device_model;
    localparam int CL = 6, CWL = 5, TRCD = 6, TRP = 6;

    logic        clk = 1'b0, rst_n = 1'b0, cke = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  ba = '0;
    logic [13:0] addr = '0;
    logic [15:0] dq_i [1:0];
    logic [15:0] dq_o [1:0];
    logic        oe;
    logic [3:0]  err;
    logic [15:0] rc;

    sddr_device_model dut (
        .ddr_clock_i(clk), .ddr_reset_n_i(rst_n), .ddr3_cke_i(cke),
        .ddr3_cs_n_i(cs_n), .ddr3_ras_n_i(ras_n), .ddr3_cas_n_i(cas_n), .ddr3_we_n_i(we_n),
        .ddr3_ba_i(ba), .ddr3_addr_i(addr), .ddr3_dq_i(dq_i), .ddr3_dq_o(dq_o),
        .ddr3_dq_oe_o(oe), .err_o(err), .refresh_count_o(rc)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [15:0] d0; logic [15:0] d1; } rd_exp_t;
    rd_exp_t     exp_q [$];
    logic [15:0] mdl [int];
    logic        open_m [8];
    int          row_m [8];
    int          n_chk = 0, n_fail = 0;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
    localparam logic [3:0] EXP_TIMING_ERR = 4'b0010;
`else
    localparam logic [3:0] EXP_TIMING_ERR = 4'b0000;
`endif

    function automatic int midx(input int b, input int r, input int c);
        return ((b << 23) | (r << 10) | c) & 1023;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_read: dq_oe_o high at cycle %0d with empty scoreboard", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_beat_even", {16'h0, dq_o[0]}, {16'h0, e.d0});
                chk("rd_beat_odd", {16'h0, dq_o[1]}, {16'h0, e.d1});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cmd(input logic [3:0] c, input int b, input int a, output int t);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = 3'(b);
        addr = 14'(a);
        @(posedge clk); #1;
        t = cyc;
        {cs_n, ras_n, cas_n, we_n} = 4'b0111;
    endtask

    task automatic act(input int b, input int r);
        int t;
        cmd(4'b0011, b, r, t);
        open_m[b] = 1'b1;
        row_m[b] = r;
    endtask

    task automatic pre_all();
        int t;
        cmd(4'b0010, 0, 1 << 10, t);
        for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
    endtask

    task automatic wr(input int b, input int c, input int ap, input logic [15:0] d [8]);
        int t;
        cmd(4'b0100, b, c | (ap << 10), t);
        tick(CWL - 1);
        for (int j = 0; j < 4; j++) begin
            dq_i[0] = d[2*j];
            dq_i[1] = d[2*j+1];
            tick(1);
        end
        for (int k = 0; k < 8; k++) mdl[midx(b, row_m[b], (c & ~7) + k)] = d[k];
        if (ap != 0) open_m[b] = 1'b0;
    endtask

    task automatic rd(input int b, input int c);
        int t;
        rd_exp_t e;
        cmd(4'b0101, b, c, t);
        for (int j = 0; j < 4; j++) begin
            e.cyc = t + CL + j;
            e.d0 = mdl[midx(b, row_m[b], (c & ~7) + 2*j)];
            e.d1 = mdl[midx(b, row_m[b], (c & ~7) + 2*j + 1)];
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        tick(3);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(3);
        for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d [8];
        int t, b, r, c, c2;
        int wcols [$];
        dq_i[0] = '0; dq_i[1] = '0;
        for (int i = 0; i < 8; i++) begin open_m[i] = 1'b0; row_m[i] = 0; end

        tick(3);
        chk("reset_oe", oe, 0);
        chk("reset_err", err, 0);
        chk("reset_refresh", rc, 0);
        chk("reset_dq0", dq_o[0], 0);
        rst_n = 1'b1;
        tick(3);

        // Write/read round trip plus a gapless second burst four cycles later.
        act(2, 'h055);
        tick(TRCD - 1);
        for (int k = 0; k < 8; k++) d[k] = 16'h1000 + 16'(k);
        wr(2, 'h010, 0, d);
        for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
        wr(2, 'h018, 0, d);
        rd(2, 'h010);
        tick(3);
        rd(2, 'h018);
        drain();
        chk("roundtrip_err", err, 0);

        do_reset();
        cmd(4'b0101, 1, 'h010, t);
        tick(CL + 6);
        chk("closed_bank_err", err, 4'b0001);

        do_reset();
        act(3, 'h1ab);
        tick(2);
        rd(3, 'h010);
        drain();
        chk("trcd_err", err, EXP_TIMING_ERR);

        do_reset();
        act(4, 'h002);
        tick(TRCD - 1);
        rd(4, 'h010);
        tick(1);
        cmd(4'b0101, 4, 'h010, t);
        drain();
        chk("overlap_err", err, 4'b0100);

        do_reset();
        act(5, 'h0f0);
        tick(TRCD - 1);
        for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
        wr(5, 'h040, 1, d);
        tick(TRP);
        act(5, 'h0f0);
        tick(TRCD - 1);
        rd(5, 'h040);
        drain();
        chk("autopre_err", err, 0);
        cmd(4'b0001, 0, 0, t);
        tick(2);
        chk("ref_open_err", err, 4'b0001);
        chk("ref_count", rc, 1);

        do_reset();
        cmd(4'b0110, 0, 0, t);
        tick(1);
        chk("zq_err", err, 4'b1000);
        act(6, 'h123);
        tick(TRCD - 1);
        rd(6, 'h040);
        tick(CL + 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midburst_oe", oe, 0);
        chk("midburst_err", err, 0);
        chk("midburst_dq0", dq_o[0], 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
        act(6, 'h123);
        tick(TRCD - 1);
        rd(6, 'h040);
        drain();
        chk("after_reset_err", err, 0);

        wcols.push_back('h010);
        wcols.push_back('h040);
        for (int it = 0; it < 16; it++) begin
            b = $urandom_range(0, 7);
            r = $urandom_range(0, 8191);
            pre_all();
            tick(TRP - 1);
            act(b, r);
            tick(TRCD - 1);
            c = $urandom_range(0, 127) << 3;
            for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
            wr(b, c, 0, d);
            wcols.push_back(c);
            tick($urandom_range(0, 3));
            c2 = wcols[$urandom_range(0, wcols.size() - 1)];
            rd(b, c2);
            tick(3);
            rd(b, c);
            drain();
        end
        chk("random_err", err, 0);
        chk("random_refresh", rc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
